// File: rtl/pipe_defs.sv
// Shared IF/ID pipeline definitions: bubble instruction, skid-buffer state encoding, payload layout.
package pipe_defs;

    localparam int unsigned PIPE_DW = 32;
    localparam logic [PIPE_DW-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Payload bundle as it sits in a slot register: {pc, pc_4, inst}
    typedef struct packed {
        logic [PIPE_DW-1:0] pc;
        logic [PIPE_DW-1:0] pc_4;
        logic [PIPE_DW-1:0] inst;
    } if_id_payload_t;

endpackage

// File: rtl/if_id_slot.sv
// One skid-buffer payload register; loads only when its slot is written.
module if_id_slot #(
    parameter int unsigned W       = 96,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer so if_ready never depends on id_ready.
module if_id_skid_reg #(
    parameter int unsigned   DW       = pipe_defs::PIPE_DW,
    parameter logic [DW-1:0] NOP_INST = DW'(pipe_defs::NOP_INST),
    parameter int unsigned   CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [DW-1:0]    if_pc,
    input  logic [DW-1:0]    if_pc_4,
    input  logic [DW-1:0]    if_inst,
    input  logic             flush,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [DW-1:0]    id_pc,
    output logic [DW-1:0]    id_pc_4,
    output logic [DW-1:0]    id_inst,
    output logic [CNT_W-1:0] stall_cnt
);

    import pipe_defs::*;

    localparam int unsigned PW = 3 * DW;
    localparam logic [PW-1:0] MAIN_RST = {{(2 * DW){1'b0}}, NOP_INST};

    state_t        state;
    logic          accept;
    logic          consume;
    logic          main_load;
    logic          skid_load;
    logic [PW-1:0] if_payload;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;

    assign accept     = if_valid & if_ready;
    assign consume    = id_valid & id_ready;
    assign if_payload = {if_pc, if_pc_4, if_inst};

    // Main refills from fetch except when draining the skid entry forward
    assign main_d    = (state == FULL) ? skid_q : if_payload;
    assign main_load = !flush && (((state == EMPTY) && accept) ||
                                  ((state == ONE) && accept && consume) ||
                                  ((state == FULL) && consume));
    assign skid_load = !flush && (state == ONE) && accept && !consume;

    if_id_slot #(.W(PW), .RST_VAL(MAIN_RST)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    if_id_slot #(.W(PW), .RST_VAL('0)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (if_payload),
        .q    (skid_q)
    );

    // State plus the registered handshake outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            id_valid <= 1'b0;
            if_ready <= 1'b1;
        end else if (flush) begin
            state    <= EMPTY;
            id_valid <= 1'b0;
            if_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state    <= ONE;
                        id_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !consume) begin
                        state    <= FULL;
                        if_ready <= 1'b0;
                    end else if (!accept && consume) begin
                        state    <= EMPTY;
                        id_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state    <= ONE;
                        if_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    id_valid <= 1'b0;
                    if_ready <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of ID hazard-stall cycles; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_valid && !id_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign id_pc   = main_q[PW-1:2*DW];
    assign id_pc_4 = main_q[2*DW-1:DW];
    assign id_inst = id_valid ? main_q[DW-1:0] : NOP_INST;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for the IF/ID skid register.
module tb_if_id_skid_reg;

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_valid;
    logic             if_ready;
    logic [DW-1:0]    if_pc;
    logic [DW-1:0]    if_pc_4;
    logic [DW-1:0]    if_inst;
    logic             flush;
    logic             id_valid;
    logic             id_ready;
    logic [DW-1:0]    id_pc;
    logic [DW-1:0]    id_pc_4;
    logic [DW-1:0]    id_inst;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    if_id_skid_reg #(.DW(DW), .NOP_INST(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc     (if_pc),
        .if_pc_4   (if_pc_4),
        .if_inst   (if_inst),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_pc_4   (id_pc_4),
        .id_inst   (id_inst),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        if_pc   = pc;
        if_pc_4 = pc + 32'd4;
        if_inst = 32'h2000_0000 | pc;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; flush = 1'b0; id_ready = 1'b0;
        offer(32'h0);
        step(); step();
        rst = 1'b0;
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd1);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_pc_4", id_pc_4, 32'h0);
        check("rst_id_inst", id_inst, 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

        // Streaming
        if_valid = 1'b1; id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(32'(4 * i));
            step();
            check("stream_valid", 32'(id_valid), 32'd1);
            check("stream_pc", id_pc, 32'(4 * i));
            check("stream_inst", id_inst, 32'h2000_0000 | 32'(4 * i));
            check("stream_if_ready", 32'(if_ready), 32'd1);
        end
        check("stream_stall_cnt", 32'(stall_cnt), 32'd0);

        // Stall into FULL, then drain in order
        offer(32'h10); step();
        check("stall_main_pc", id_pc, 32'h10);
        id_ready = 1'b0; offer(32'h14);
        step();
        check("stall_if_ready", 32'(if_ready), 32'd0);
        step(); step();
        check("stall_cnt3", 32'(stall_cnt), 32'd3);
        check("stall_hold_pc", id_pc, 32'h10);
        id_ready = 1'b1; if_valid = 1'b0;
        step();
        check("drain_pc1", id_pc, 32'h14);
        check("drain_pc4_1", id_pc_4, 32'h18);
        check("drain_if_ready", 32'(if_ready), 32'd1);
        step();
        check("drain_empty", 32'(id_valid), 32'd0);
        check("drain_nop", id_inst, 32'h0);
        check("drain_cnt", 32'(stall_cnt), 32'd3);

        // Flush while FULL with a new offer present
        id_ready = 1'b0; if_valid = 1'b1;
        offer(32'h20); step();
        offer(32'h24); step();
        check("flfull_pc", id_pc, 32'h20);
        check("flfull_if_ready", 32'(if_ready), 32'd0);
        offer(32'h28); flush = 1'b1;
        step();
        flush = 1'b0; if_valid = 1'b0;
        check("flush_valid", 32'(id_valid), 32'd0);
        check("flush_inst", id_inst, 32'h0);
        check("flush_if_ready", 32'(if_ready), 32'd1);
        check("flush_cnt_kept", 32'(stall_cnt), 32'd5);
        step();
        check("flush_no_0x28", 32'(id_valid), 32'd0);

        // Reset while FULL
        if_valid = 1'b1;
        offer(32'h30); step();
        offer(32'h34); step();
        check("prerst_if_ready", 32'(if_ready), 32'd0);
        check("prerst_cnt", 32'(stall_cnt), 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0; if_valid = 1'b0;
        check("mrst_valid", 32'(id_valid), 32'd0);
        check("mrst_if_ready", 32'(if_ready), 32'd1);
        check("mrst_cnt", 32'(stall_cnt), 32'd0);
        check("mrst_pc", id_pc, 32'h0);
        step();
        check("mrst_stays_empty", 32'(id_valid), 32'd0);

        // Bubble then resume
        id_ready = 1'b1; if_valid = 1'b1;
        offer(32'h38); step();
        check("bub_pc", id_pc, 32'h38);
        if_valid = 1'b0;
        step();
        check("bub_valid", 32'(id_valid), 32'd0);
        check("bub_nop", id_inst, 32'h0);
        check("bub_pc_hold", id_pc, 32'h38);
        step();
        check("bub_valid2", 32'(id_valid), 32'd0);
        if_valid = 1'b1; offer(32'h40);
        step();
        if_valid = 1'b0;
        check("resume_pc", id_pc, 32'h40);
        check("resume_valid", 32'(id_valid), 32'd1);
        step();
        check("resume_no_dup", 32'(id_valid), 32'd0);
        check("resume_cnt", 32'(stall_cnt), 32'd0);

        // Counter saturation
        id_ready = 1'b0; if_valid = 1'b1;
        offer(32'h50); step();
        if_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            check("sat_cnt", 32'(stall_cnt), (i < 15) ? 32'(i) : 32'd15);
        end
        check("sat_pc", id_pc, 32'h50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
